// File: rtl/dsp48a1_mac_sequencer.sv
// dsp48a1_mac_sequencer
// Drives a single DSP48A1 slice as a signed 18x18 multiply-accumulate engine.
// Operand pairs arrive over a valid/ready stream and are issued to the slice
// pins one cycle after acceptance. The OPMODE for each term is delayed so it
// reaches the slice OPMODE register just as the product reaches the P stage.
// After the last term the controller waits out the slice pipeline, captures
// P, and presents the dot product with its term count on a valid/ready port.
module dsp48a1_mac_sequencer #(
  parameter int PIPE_LAT  = 3,
  parameter int OPMODEREG = 1,
  parameter int CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_p,
  output logic [CNT_W-1:0] m_count,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);

  // Extra OPMODE stages needed so a term's OPMODE lands in the slice OPMODE
  // register in the same cycle its product sits in the M register.
  localparam int OP_DLY = PIPE_LAT - 1 - OPMODEREG;

  // Drain counter covers PIPE_LAT+1 cycles (load PIPE_LAT, expire at zero).
  localparam int DRN_W = (PIPE_LAT + 1 > 2) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(PIPE_LAT);
  localparam logic [DRN_W-1:0] DRN_ONE  = DRN_W'(1);
  localparam logic [DRN_W-1:0] DRN_ZERO = DRN_W'(0);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // X=M, Z=0: first term overwrites whatever P held from a previous vector.
  localparam logic [7:0] OP_FIRST = 8'b0000_0001;
  // X=M, Z=P: accumulate a term (or a zero bubble).
  localparam logic [7:0] OP_ACC   = 8'b0000_1001;
  // X=0, Z=P: keep P unchanged when no term occupies the slot.
  localparam logic [7:0] OP_HOLD  = 8'b0000_1000;
  localparam logic [7:0] OP_ZERO  = 8'b0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic             s_ready_q,  s_ready_d;
  logic             m_valid_q,  m_valid_d;
  logic [47:0]      m_p_q,      m_p_d;
  logic [CNT_W-1:0] m_count_q,  m_count_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic [DRN_W-1:0] drain_q,    drain_d;
  logic [17:0]      dsp_a_q,    dsp_a_d;
  logic [17:0]      dsp_b_q,    dsp_b_d;
  logic [7:0]       op_slot_q,  op_slot_d;
  logic             dsp_ce_q,   dsp_ce_d;
  logic             dsp_rst_q,  dsp_rst_d;
  logic             flush_q,    flush_d;

  logic             accept_s;

  // Saturating term counter increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  assign accept_s = s_valid & s_ready_q;

  // Next-state and registered-output decode for the sequencer FSM.
  always_comb begin
    state_d    = state_q;
    s_ready_d  = s_ready_q;
    m_valid_d  = m_valid_q;
    m_p_d      = m_p_q;
    m_count_d  = m_count_q;
    term_cnt_d = term_cnt_q;
    drain_d    = drain_q;
    dsp_a_d    = 18'h0_0000;
    dsp_b_d    = 18'h0_0000;
    op_slot_d  = OP_HOLD;
    dsp_ce_d   = 1'b1;
    dsp_rst_d  = 1'b0;
    flush_d    = 1'b0;

    if (flush_q) begin
      // One extra cycle of slice reset after RST falls; controller stays parked.
      state_d    = ST_IDLE;
      s_ready_d  = 1'b0;
      m_valid_d  = 1'b0;
      m_p_d      = 48'h0;
      m_count_d  = CNT_ZERO;
      term_cnt_d = CNT_ZERO;
      drain_d    = DRN_ZERO;
      op_slot_d  = OP_ZERO;
      dsp_ce_d   = 1'b0;
      dsp_rst_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            dsp_a_d    = s_a;
            dsp_b_d    = s_b;
            op_slot_d  = OP_FIRST;
            term_cnt_d = CNT_ONE;
            if (s_last) begin
              state_d   = ST_DRAIN;
              s_ready_d = 1'b0;
              drain_d   = DRN_LOAD;
            end else begin
              state_d   = ST_ISSUE;
              s_ready_d = 1'b1;
            end
          end else begin
            s_ready_d = 1'b1;
          end
        end
        ST_ISSUE: begin
          // Every ISSUE cycle occupies a slot: a real term or a zero bubble.
          op_slot_d = OP_ACC;
          if (accept_s) begin
            dsp_a_d    = s_a;
            dsp_b_d    = s_b;
            term_cnt_d = sat_inc(term_cnt_q);
            if (s_last) begin
              state_d   = ST_DRAIN;
              s_ready_d = 1'b0;
              drain_d   = DRN_LOAD;
            end else begin
              s_ready_d = 1'b1;
            end
          end else begin
            s_ready_d = 1'b1;
          end
        end
        ST_DRAIN: begin
          s_ready_d = 1'b0;
          if (drain_q == DRN_ZERO) begin
            m_p_d     = dsp_p;
            m_count_d = term_cnt_q;
            m_valid_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            drain_d = drain_q - DRN_ONE;
          end
        end
        ST_DONE: begin
          if (m_ready) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            s_ready_d = 1'b1;
          end else begin
            m_valid_d = 1'b1;
            s_ready_d = 1'b0;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          s_ready_d = 1'b0;
          m_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; RST clears everything and arms the flush cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_p_q      <= 48'h0;
      m_count_q  <= CNT_ZERO;
      term_cnt_q <= CNT_ZERO;
      drain_q    <= DRN_ZERO;
      dsp_a_q    <= 18'h0_0000;
      dsp_b_q    <= 18'h0_0000;
      op_slot_q  <= OP_ZERO;
      dsp_ce_q   <= 1'b0;
      dsp_rst_q  <= 1'b1;
      flush_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      m_p_q      <= m_p_d;
      m_count_q  <= m_count_d;
      term_cnt_q <= term_cnt_d;
      drain_q    <= drain_d;
      dsp_a_q    <= dsp_a_d;
      dsp_b_q    <= dsp_b_d;
      op_slot_q  <= op_slot_d;
      dsp_ce_q   <= dsp_ce_d;
      dsp_rst_q  <= dsp_rst_d;
      flush_q    <= flush_d;
    end
  end

  generate
    if (OP_DLY == 0) begin : g_op_direct
      assign dsp_opmode = op_slot_q;
    end else begin : g_op_delay
      logic [7:0] op_line_q [OP_DLY];

      // OPMODE delay line aligning each slot code with its product.
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < OP_DLY; i++) begin
            op_line_q[i] <= OP_ZERO;
          end
        end else begin
          op_line_q[0] <= op_slot_q;
          for (int i = 1; i < OP_DLY; i++) begin
            op_line_q[i] <= op_line_q[i-1];
          end
        end
      end

      assign dsp_opmode = op_line_q[OP_DLY-1];
    end
  endgenerate

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_p     = m_p_q;
  assign m_count = m_count_q;
  assign dsp_a   = dsp_a_q;
  assign dsp_b   = dsp_b_q;
  assign dsp_ce  = dsp_ce_q;
  assign dsp_rst = dsp_rst_q;

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer: a behavioural DSP48A1 slice (A1/B1, M, P
// and OPMODE registers, sync reset, CE) closes the loop; expected dot
// products are queued when the last pair is driven and compared when the
// result handshake fires.
module tb_dsp48a1_mac_sequencer;

  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [17:0]      s_a = 18'h0;
  logic [17:0]      s_b = 18'h0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [47:0]      m_p;
  logic [CNT_W-1:0] m_count;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic             dsp_rst;
  logic [47:0]      dsp_p;

  dsp48a1_mac_sequencer #(.PIPE_LAT(3), .OPMODEREG(1), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_p(m_p), .m_count(m_count),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_ce(dsp_ce), .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural DSP48A1 slice ----------------
  logic signed [17:0] a1_r, b1_r;
  logic [47:0]        m_r, p_r;
  logic [7:0]         opr_r;
  logic [47:0]        x_mux, z_mux;

  function automatic logic [47:0] sext36(input logic [35:0] v);
    return {{12{v[35]}}, v};
  endfunction

  assign x_mux = (opr_r[1:0] == 2'b01) ? m_r : 48'h0;
  assign z_mux = (opr_r[3:2] == 2'b10) ? p_r : 48'h0;
  assign dsp_p = p_r;

  always @(posedge CLK) begin
    if (dsp_rst) begin
      a1_r <= 18'sh0; b1_r <= 18'sh0; m_r <= 48'h0; p_r <= 48'h0; opr_r <= 8'h0;
    end else if (dsp_ce) begin
      a1_r  <= dsp_a;
      b1_r  <= dsp_b;
      m_r   <= sext36(a1_r * b1_r);
      opr_r <= dsp_opmode;
      p_r   <= z_mux + x_mux;
    end
  end

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic [47:0] p;
    logic [15:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   mv_rise_cyc = 0;
  int   mv_rises = 0;
  logic mv_prev = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [47:0] p, input logic [15:0] c);
    exp_t e;
    e.p = p;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one pair and hold it until accepted; records the accept cycle.
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    bit done = 1'b0;
    s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
    for (int k = 0; k < 100 && !done; k++) begin
      if (s_ready) begin
        acc_cyc = cyc;
        done = 1'b1;
      end
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0; s_a = 18'h0; s_b = 18'h0;
    chk("send_accepted", {63'd0, done}, 64'd1);
  endtask

  // Wait until all queued results are consumed and the controller is idle.
  task automatic wait_drained(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (sb.size() == 0 && s_ready) done = 1'b1;
      else tick();
    end
    chk(tag, {63'd0, done}, 64'd1);
  endtask

  // Result monitor: scoreboard pop on handshake, valid-rise tracking.
  always @(negedge CLK) begin
    if (m_valid && !mv_prev) begin
      mv_rise_cyc = cyc;
      mv_rises++;
    end
    mv_prev = m_valid;
    if (m_valid && m_ready) begin
      chk("result_expected", {63'd0, (sb.size() != 0)}, 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("m_p", {16'd0, m_p}, {16'd0, e.p});
        chk("m_count", {48'd0, m_count}, {48'd0, e.c});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int last_acc;
    int rises0;
    bit seen;

    // ---- reset ----
    tick(); tick();
    chk("rst_s_ready",  {63'd0, s_ready}, 64'd0);
    chk("rst_m_valid",  {63'd0, m_valid}, 64'd0);
    chk("rst_m_p",      {16'd0, m_p}, 64'd0);
    chk("rst_m_count",  {48'd0, m_count}, 64'd0);
    chk("rst_dsp_a",    {46'd0, dsp_a}, 64'd0);
    chk("rst_dsp_op",   {56'd0, dsp_opmode}, 64'd0);
    chk("rst_dsp_ce",   {63'd0, dsp_ce}, 64'd0);
    chk("rst_dsp_rst",  {63'd0, dsp_rst}, 64'd1);
    RST = 1'b0;
    tick();
    chk("flush_dsp_rst", {63'd0, dsp_rst}, 64'd1);
    chk("flush_dsp_ce",  {63'd0, dsp_ce}, 64'd0);
    tick();
    chk("post_dsp_rst",  {63'd0, dsp_rst}, 64'd0);
    chk("post_dsp_ce",   {63'd0, dsp_ce}, 64'd1);
    chk("post_s_ready",  {63'd0, s_ready}, 64'd1);
    m_ready = 1'b1;

    // ---- 1: three-term dot product, latency ----
    send(18'd2, 18'd3, 1'b0);
    send(18'd4, 18'd5, 1'b0);
    push(48'h44, 16'd3);
    send(18'd6, 18'd7, 1'b1);
    last_acc = acc_cyc;
    wait_drained("t1_drained");
    chk("t1_latency", 64'(mv_rise_cyc - last_acc), 64'd5);

    // ---- 2: single negative term ----
    push(48'hFFFF_FFFF_FFFB, 16'd1);
    send(18'h3FFFF, 18'd5, 1'b1);
    last_acc = acc_cyc;
    wait_drained("t2_drained");
    chk("t2_latency", 64'(mv_rise_cyc - last_acc), 64'd5);

    // ---- 3: bubbles between terms ----
    send(18'd2, 18'd3, 1'b0);
    chk("t3_pin_a", {46'd0, dsp_a}, 64'd2);
    chk("t3_pin_b", {46'd0, dsp_b}, 64'd3);
    tick();
    chk("t3_bubble_a", {46'd0, dsp_a}, 64'd0);
    chk("t3_first_op", {56'd0, dsp_opmode}, 64'h01);
    tick();
    chk("t3_bubble1_op", {56'd0, dsp_opmode}, 64'h09);
    push(48'h1A, 16'd2);
    send(18'd4, 18'd5, 1'b1);
    chk("t3_bubble2_op", {56'd0, dsp_opmode}, 64'h09);
    chk("t3_pin_a2", {46'd0, dsp_a}, 64'd4);
    wait_drained("t3_drained");

    // ---- 4: result back-pressure ----
    m_ready = 1'b0;
    push(48'h64, 16'd1);
    send(18'd10, 18'd10, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (m_valid) seen = 1'b1;
      else begin
        chk("t4_drain_s_ready", {63'd0, s_ready}, 64'd0);
        tick();
      end
    end
    chk("t4_m_valid_seen", {63'd0, seen}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold_valid",   {63'd0, m_valid}, 64'd1);
      chk("t4_hold_p",       {16'd0, m_p}, 64'h64);
      chk("t4_hold_s_ready", {63'd0, s_ready}, 64'd0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    chk("t4_valid_drop", {63'd0, m_valid}, 64'd0);
    chk("t4_ready_back", {63'd0, s_ready}, 64'd1);
    wait_drained("t4_drained");

    // ---- 5: reset mid-vector ----
    rises0 = mv_rises;
    send(18'd1, 18'd2, 1'b0);
    send(18'd3, 18'd4, 1'b0);
    RST = 1'b1;
    tick();
    chk("t5_rst_dsp_rst", {63'd0, dsp_rst}, 64'd1);
    chk("t5_rst_s_ready", {63'd0, s_ready}, 64'd0);
    RST = 1'b0;
    tick();
    chk("t5_flush_dsp_rst", {63'd0, dsp_rst}, 64'd1);
    tick();
    chk("t5_after_dsp_rst", {63'd0, dsp_rst}, 64'd0);
    for (int k = 0; k < 10; k++) tick();
    chk("t5_no_result", 64'(mv_rises), 64'(rises0));
    push(48'h1, 16'd1);
    send(18'd1, 18'd1, 1'b1);
    wait_drained("t5_drained");
    chk("t5_one_result", 64'(mv_rises), 64'(rises0 + 1));

    // ---- 6: back-to-back single-term vectors ----
    push(48'h9, 16'd1);
    send(18'd3, 18'd3, 1'b1);
    push(48'h4, 16'd1);
    send(18'd2, 18'd2, 1'b1);
    wait_drained("t6_drained");

    // ---- 7: mixed signs ----
    send(18'h3FFFD, 18'd7, 1'b0);
    send(18'd5, 18'h3FFFE, 1'b0);
    push(48'hFFFF_FFFF_FFF1, 16'd3);
    send(18'h3FFFC, 18'h3FFFC, 1'b1);
    wait_drained("t7_drained");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
